// File: rtl/keypad_scan_pkg.sv
// Shared keypad constants, column strobes and key-map helpers.
package keypad_scan_pkg;

  localparam int unsigned KP_COLS   = 4;
  localparam int unsigned KP_ROWS   = 4;
  localparam int unsigned KP_CODE_W = 4;
  localparam int unsigned KP_KEYS   = KP_COLS * KP_ROWS;
  localparam int unsigned KP_POP_W  = $clog2(KP_KEYS + 1);

  localparam logic [KP_COLS-1:0] COL0_STROBE = 4'b1110;
  localparam logic [KP_COLS-1:0] COL1_STROBE = 4'b1101;
  localparam logic [KP_COLS-1:0] COL2_STROBE = 4'b1011;
  localparam logic [KP_COLS-1:0] COL3_STROBE = 4'b0111;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_t;

  typedef struct packed {
    logic                 valid;
    logic [KP_CODE_W-1:0] code;
  } key_event_t;

  // Lowest set bit index of a key map (0 when empty).
  function automatic logic [KP_CODE_W-1:0] lowest_index(input logic [KP_KEYS-1:0] m);
    lowest_index = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (m[i]) lowest_index = KP_CODE_W'(i);
    end
  endfunction

  function automatic logic [KP_POP_W-1:0] popcount(input logic [KP_KEYS-1:0] m);
    popcount = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      popcount = popcount + KP_POP_W'(m[i]);
    end
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: publishes the frame map once it repeats DEBOUNCE times.
module keypad_debounce
  import keypad_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KP_KEYS-1:0] frame_map,
  input  logic               frame_done,
  output logic [KP_KEYS-1:0] key_map,
  output logic               map_upd
);

  localparam int unsigned CNT_W = 4;

  logic [KP_KEYS-1:0] prev;
  logic [CNT_W-1:0]   stable_cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Saturating count of consecutive identical frames.
  always_comb begin
    cnt_nxt = '0;
    if (frame_map == prev) begin
      cnt_nxt = (stable_cnt == '1) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev       <= '0;
      stable_cnt <= '0;
      key_map    <= '0;
      map_upd    <= 1'b0;
    end else begin
      map_upd <= 1'b0;
      if (frame_done) begin
        stable_cnt <= cnt_nxt;
        prev       <= frame_map;
        if (cnt_nxt == CNT_W'(DEBOUNCE)) begin
          key_map <= frame_map;
          map_upd <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with debounced key-press events under valid/ack.
// Optional auto-repeat of a single held key: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [KP_COLS-1:0]   col_o,
  input  logic [KP_ROWS-1:0]   row_i,
  output logic                 key_valid,
  output logic [KP_CODE_W-1:0] key_code,
  input  logic                 key_ack,
  output logic                 overrun,
  output logic                 multi,
  output logic [KP_KEYS-1:0]   key_map
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  scan_state_t        state;
  logic [DIV_W-1:0]   div;
  logic [KP_ROWS-1:0] row_meta;
  logic [KP_ROWS-1:0] row_sync;
  logic [KP_KEYS-1:0] raw;
  logic               frame_done;
  logic               map_upd;
  logic [KP_KEYS-1:0] key_map_old;
  logic [KP_KEYS-1:0] new_press_c;
  logic               ev_multi_c;
  key_event_t         ev_c;

  // Rows idle high, so the synchroniser resets to the released level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
    end
  end

  // Column scan: sample the rows at the end of each slot, then strobe the next column.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= COL0;
      col_o      <= COL0_STROBE;
      div        <= '0;
      raw        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (div == DIV_LAST) begin
        div <= '0;
        unique case (state)
          COL0: begin
            raw[0*KP_ROWS +: KP_ROWS] <= ~row_sync;
            state <= COL1;
            col_o <= COL1_STROBE;
          end
          COL1: begin
            raw[1*KP_ROWS +: KP_ROWS] <= ~row_sync;
            state <= COL2;
            col_o <= COL2_STROBE;
          end
          COL2: begin
            raw[2*KP_ROWS +: KP_ROWS] <= ~row_sync;
            state <= COL3;
            col_o <= COL3_STROBE;
          end
          COL3: begin
            raw[3*KP_ROWS +: KP_ROWS] <= ~row_sync;
            state      <= COL0;
            col_o      <= COL0_STROBE;
            frame_done <= 1'b1;
          end
        endcase
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .frame_map  (raw),
    .frame_done (frame_done),
    .key_map    (key_map),
    .map_upd    (map_upd)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic             frame_tick;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             rpt_hold_c;
  logic             rpt_fire_c;

  // key_map_old still holds the previous map in the tick cycle, so it flags a change.
  always_comb begin
    rpt_hold_c = (popcount(key_map) == KP_POP_W'(1)) && (key_map == key_map_old);
    rpt_fire_c = 1'b0;
    if (frame_tick && rpt_hold_c) begin
      rpt_fire_c = rpt_first ? (rpt_cnt + RPT_W'(1) == RPT_W'(REPEAT_DELAY))
                             : (rpt_cnt + RPT_W'(1) == RPT_W'(REPEAT_RATE));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_tick <= 1'b0;
      rpt_cnt    <= '0;
      rpt_first  <= 1'b1;
    end else begin
      frame_tick <= frame_done;
      if (frame_tick) begin
        if (!rpt_hold_c) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b1;
        end else if (rpt_fire_c) begin
          rpt_cnt   <= '0;
          rpt_first <= 1'b0;
        end else begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Event source: newly pressed keys after a map update (plus repeats when enabled).
  always_comb begin
    new_press_c = key_map & ~key_map_old;
    ev_c        = '0;
    ev_multi_c  = 1'b0;
    if (map_upd && (new_press_c != '0)) begin
      ev_c.valid = 1'b1;
      ev_c.code  = lowest_index(new_press_c);
      ev_multi_c = popcount(new_press_c) > KP_POP_W'(1);
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    else if (rpt_fire_c) begin
      ev_c.valid = 1'b1;
      ev_c.code  = lowest_index(key_map);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_map_old <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      overrun     <= 1'b0;
      multi       <= 1'b0;
    end else begin
      if (map_upd) key_map_old <= key_map;
      if (ev_c.valid) begin
        if (!key_valid || key_ack) begin
          key_valid <= 1'b1;
          key_code  <= ev_c.code;
        end else begin
          overrun <= 1'b1;
        end
        if (ev_multi_c) multi <= 1'b1;
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
        multi     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a combinational keypad model on col_o/row_i.
module tb_keypad_scan;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col_o;
  logic [3:0]  row_i;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        overrun;
  logic        multi;
  logic [15:0] key_map;

  logic [15:0] keys;
  logic        rows_low;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  keypad_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE     (2),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_o     (col_o),
    .row_i     (row_i),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .overrun   (overrun),
    .multi     (multi),
    .key_map   (key_map)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key (c*4+r) pulls row r low while column c is strobed.
  always_comb begin
    row_i = 4'hF;
    if (rows_low) row_i = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (!col_o[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) row_i[r] = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!key_valid && n < max_cyc) begin
      step(1);
      n++;
    end
    check_eq({tag, "_seen"}, 32'(key_valid), 32'd1);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  // Release everything and acknowledge whatever is still in flight.
  task automatic settle(input int frames);
    keys = 16'h0;
    for (int i = 0; i < frames * FRAME; i++) begin
      key_ack = key_valid;
      step(1);
    end
    key_ack = 1'b0;
    step(1);
  endtask

  initial begin
    keys     = 16'h0;
    rows_low = 1'b1;
    key_ack  = 1'b0;
    reset    = 1'b0;
    step(3);
    check_eq("rst_col", 32'(col_o), 32'hE);
    check_eq("rst_valid", 32'(key_valid), 32'd0);
    check_eq("rst_code", 32'(key_code), 32'd0);
    check_eq("rst_map", 32'(key_map), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_multi", 32'(multi), 32'd0);

    rows_low = 1'b0;
    reset    = 1'b1;
    step(1);
    check_eq("scan_c0", 32'(col_o), 32'hE);
    step(3);
    check_eq("scan_c1", 32'(col_o), 32'hD);
    step(4);
    check_eq("scan_c2", 32'(col_o), 32'hB);
    step(4);
    check_eq("scan_c3", 32'(col_o), 32'h7);
    step(4);
    check_eq("scan_wrap", 32'(col_o), 32'hE);
    step(2 * FRAME);

    // Single press of col2/row1 -> code 9
    keys = 16'h0200;
    wait_valid("single", 5 * FRAME + 4);
    check_eq("single_code", 32'(key_code), 32'd9);
    check_eq("single_map", 32'(key_map), 32'h0200);
    ack_pulse();
    check_eq("single_ack", 32'(key_valid), 32'd0);
`ifndef KEYPAD_AUTOREPEAT_EN
    step(3 * FRAME);
    check_eq("single_no_repeat", 32'(key_valid), 32'd0);
`endif
    settle(6);
    check_eq("release_map", 32'(key_map), 32'h0);

    // Contact bouncing every frame must not produce an event
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      step(FRAME);
      check_eq($sformatf("bounce_valid%0d", i), 32'(key_valid), 32'd0);
      check_eq($sformatf("bounce_map%0d", i), 32'(key_map), 32'h0);
    end
    keys = 16'h0200;
    wait_valid("bounce", 6 * FRAME);
    check_eq("bounce_code", 32'(key_code), 32'd9);
    ack_pulse();
`ifndef KEYPAD_AUTOREPEAT_EN
    step(3 * FRAME);
    check_eq("bounce_single_event", 32'(key_valid), 32'd0);
`endif
    settle(6);

    // Unacknowledged event followed by another press
    keys = 16'h0001;
    wait_valid("ovr_first", 6 * FRAME);
    check_eq("ovr_first_code", 32'(key_code), 32'd0);
    keys = 16'h0000;
    step(4 * FRAME);
    keys = 16'h8000;
    step(7 * FRAME);
    check_eq("ovr_valid", 32'(key_valid), 32'd1);
    check_eq("ovr_code_kept", 32'(key_code), 32'd0);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_map", 32'(key_map), 32'h8000);
    ack_pulse();
    check_eq("ovr_ack_flag", 32'(overrun), 32'd0);
    check_eq("ovr_ack_valid", 32'(key_valid), 32'd0);
    settle(6);

    // Codes 3 and 12 in the same frame
    keys = 16'h1008;
    wait_valid("multi", 6 * FRAME);
    check_eq("multi_code", 32'(key_code), 32'd3);
    check_eq("multi_flag", 32'(multi), 32'd1);
    check_eq("multi_map", 32'(key_map), 32'h1008);
    ack_pulse();
    check_eq("multi_ack_clear", 32'(multi), 32'd0);
    settle(6);

`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int unsigned t0, t1, t2;
      int          busy;
      keys = 16'h0020;
      wait_valid("rpt_first", 6 * FRAME);
      t0 = cyc;
      check_eq("rpt_first_code", 32'(key_code), 32'd5);
      ack_pulse();
      wait_valid("rpt_1", 4 * FRAME);
      t1 = cyc;
      check_eq("rpt_1_code", 32'(key_code), 32'd5);
      check_eq("rpt_1_delay", t1 - t0, 32'(3 * FRAME));
      ack_pulse();
      wait_valid("rpt_2", 4 * FRAME);
      t2 = cyc;
      check_eq("rpt_2_delay", t2 - t1, 32'(2 * FRAME));
      ack_pulse();
      keys = 16'h0021;
      for (int i = 0; i < 8 * FRAME; i++) begin
        key_ack = key_valid;
        step(1);
      end
      key_ack = 1'b0;
      step(1);
      check_eq("rpt_two_map", 32'(key_map), 32'h0021);
      busy = 0;
      for (int i = 0; i < 6 * FRAME; i++) begin
        if (key_valid) busy++;
        step(1);
      end
      check_eq("rpt_stopped", 32'(busy), 32'd0);
      settle(6);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad on the PMOD headers: drives one column low at a time, reads the rows, debounces the full 16-key frame and emits key-press events.
- Each event is a 4-bit key code under a valid/ack handshake.
- It is the input-direction counterpart of the multiplexed 7-segment scanner: same time-multiplexed strobe scheme, data flowing into the computer.
- Sits in the board top between the PMOD pins and a computer input port (PORTI/PORTJ-style word).

Parameters:
- SCAN_DIV, 1000: clk cycles per column slot (1 ms at 1 MHz); legal minimum 4.
- DEBOUNCE, 4: consecutive identical frame comparisons required before the debounced map is updated; legal range 1..15.
- REPEAT_DELAY, 50: frames a single key is held before the first auto-repeat (KEYPAD_AUTOREPEAT_EN only).
- REPEAT_RATE, 10: frames between subsequent repeats (KEYPAD_AUTOREPEAT_EN only).

Ports:
- clk  in  1  block clock
- reset  in  1  synchronous reset, active-low
- col_o  out  4  column strobes, active-low, one-hot-low
- row_i  in  4  row sense, pulled up, low = pressed; asynchronous to clk
- key_valid  out  1  event pending
- key_code  out  4  code of the pending event = col*4 + row
- key_ack  in  1  consumer acknowledge
- overrun  out  1  sticky: an event was lost while key_valid was high
- multi  out  1  sticky: more than one new press in one frame
- key_map  out  16  debounced pressed map, bit col*4+row

Behaviour:
- Reset (reset==0 at posedge clk): col_o=4'b1110, column index 0, divider 0, raw/previous/debounced maps 0, stable count 0, key_valid=0, key_code=0, overrun=0, multi=0, key_map=0. Reset mid-scan or mid-handshake discards all state, including a pending event.
- Synchronisation: row_i passes through a 2-FF synchroniser.
- Scan FSM: one state per column, COL0 to COL1 to COL2 to COL3 to COL0.
  - In each state the divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: raw[col*4 +: 4] <= ~row_sync, then advance to the next column and its col_o pattern. The divider wraps to 0.
- Frame end: the sample taken in COL3 completes a frame. frame_done pulses high the next cycle.
- Debounce, on frame_done:
  - If raw == prev, stable count increments (saturating at 15); otherwise it clears to 0.
  - prev <= raw.
  - When the updated count equals DEBOUNCE: key_map <= raw.
- Event generation, one cycle after a key_map update:
  - new = key_map & ~key_map_old.
  - If new != 0, the lowest set index becomes the event.
  - If popcount(new) > 1, multi <= 1.
- Handshake:
  - When an event is generated and key_valid==0, or key_ack==1 in the same cycle: key_valid <= 1, key_code <= index.
  - When an event is generated, key_valid==1 and key_ack==0: key_code is unchanged and overrun <= 1.
  - key_ack with no new event: key_valid <= 0, overrun <= 0, multi <= 0.
  - key_ack while key_valid==0: ignored.
- Releases produce no events; they only clear key_map bits.
- Latency: a stable press is reported at most (DEBOUNCE+2)*4*SCAN_DIV + 4 cycles after its first sampled slot.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- Defined:
  - While key_map has exactly one bit set, a frame counter runs.
  - After REPEAT_DELAY frames it emits that key's code as a new event, then again every REPEAT_RATE frames, with the same handshake and overrun rules.
  - The counter clears whenever key_map changes or has ≠1 bit set.
- Undefined: no repeat logic; each press yields exactly one event; REPEAT_* parameters are unused.

Decomposition:
- Shared header (defs.v): KP_COLS=4, KP_ROWS=4, KP_CODE_W=4, and the column-strobe encodings for COL0..COL3.
- One sub-module, keypad_debounce: takes the frame map and frame_done; owns prev, the stable count and key_map, and outputs key_map plus its update pulse. The scan FSM and handshake stay in keypad_scan.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, frame = 16 cycles):
- Reset: hold reset=0 for 3 cycles with all rows low -> col_o=4'b1110, key_valid=0, key_map=0, overrun=0. After release, col_o steps 1110, 1101, 1011, 0111 every 4 cycles.
- Single press: model ties row1 low only while col_o=4'b1011 (col2), for 6 frames -> key_valid=1, key_code=4'd9 within 4 frames, key_map=16'h0200. Ack -> key_valid=0. Hold continues -> no second event.
- Bounce: toggle the col2/row1 contact every frame for 5 frames, then hold steady -> no event during toggling; exactly one event with key_code=9 after 3 steady frames.
- Overrun: press code 0, do not ack, release, press code 15 -> key_code stays 4'd0, overrun=1. Ack -> overrun=0, key_valid=0.
- Simultaneous: codes 3 and 12 pressed in the same frame -> key_code=4'd3, multi=1, key_map=16'h1008.
- Autorepeat (macro on, REPEAT_DELAY=3, REPEAT_RATE=2, bench acks every event): hold code 5 -> first event, then repeats 3 frames after the debounced press and every 2 frames after that. Adding a second key stops the repeats.
